// File: rtl/cam_pixel_capture.sv
// DVP camera capture: assembles byte pairs into RGB444/RGB565 pixels, crops to H_ACT x V_ACT and
// writes them at line-aligned addresses. Optional colour-bar generator under `CAM_TESTPAT_EN`.
module cam_pixel_capture #(
  parameter int DATA_W = 8,
  parameter int PIX_W  = 12,
  parameter int H_ACT  = 640,
  parameter int V_ACT  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              fmt,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [DATA_W-1:0] cam_data,
`ifdef CAM_TESTPAT_EN
  input  logic              tp_sel,
`endif
  input  logic              err_clr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              line_err,
  output logic              frame_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARM   = 2'd1;
  localparam logic [1:0] FRAME = 2'd2;

  localparam int X_W = $clog2(H_ACT + 1);
  localparam int Y_W = $clog2(V_ACT + 1) + 1;
  localparam logic [X_W-1:0]    H_MAX  = X_W'(H_ACT);
  localparam logic [Y_W-1:0]    V_LIM  = Y_W'(V_ACT);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACT);

  logic              vs_p0, hr_p0, vs_p1, hr_p1;
  logic [DATA_W-1:0] data_p0;
  logic [1:0]        state;
  logic              phase;
  logic [7:0]        byte_a;
  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    line_y;
  logic [ADDR_W-1:0] line_base;
  logic [PIX_W-1:0]  pix_word;

  function automatic logic [PIX_W-1:0] form_pixel(input logic f, input logic [7:0] a,
                                                  input logic [7:0] b);
    logic [11:0] p12;
    logic [15:0] p16;
    logic [15:0] r;
    p12 = f ? {a[7:4], a[2:0], b[7], b[4:1]} : {a[3:0], b};
    p16 = f ? {a, b} : {a[3:0], a[3], b[7:4], b[7:6], b[3:0], b[3]};
    r   = (PIX_W == 16) ? p16 : {4'b0, p12};
    return r[PIX_W-1:0];
  endfunction

  function automatic logic [Y_W-1:0] sat_inc_y(input logic [Y_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic vs_fall, vs_rise, hr_fall, in_frame, pix_ok, frame_end, line_bad, frame_bad;

  assign vs_fall   = vs_p1 & ~vs_p0;
  assign vs_rise   = ~vs_p1 & vs_p0;
  assign hr_fall   = hr_p1 & ~hr_p0;
  assign in_frame  = (state == FRAME);
  assign pix_ok    = in_frame & hr_p0 & phase & (pix_x < H_MAX) & (line_y < V_LIM);
  assign frame_end = in_frame & vs_rise;
  assign line_bad  = in_frame & hr_fall & (line_y < V_LIM) & ((pix_x != H_MAX) | phase);
  assign frame_bad = frame_end & (line_y != V_LIM);

`ifdef CAM_TESTPAT_EN
  localparam logic [X_W-1:0] BAR_X = X_W'(H_ACT / 8);

  function automatic logic [PIX_W-1:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c16;
    logic [11:0] c12;
    logic [15:0] r;
    case (idx)
      3'd0:    begin c16 = 16'hFFFF; c12 = 12'hFFF; end
      3'd1:    begin c16 = 16'hFFE0; c12 = 12'hFF0; end
      3'd2:    begin c16 = 16'h07FF; c12 = 12'h0FF; end
      3'd3:    begin c16 = 16'h07E0; c12 = 12'h0F0; end
      3'd4:    begin c16 = 16'hF81F; c12 = 12'hF0F; end
      3'd5:    begin c16 = 16'hF800; c12 = 12'hF00; end
      3'd6:    begin c16 = 16'h001F; c12 = 12'h00F; end
      default: begin c16 = 16'h0000; c12 = 12'h000; end
    endcase
    r = (PIX_W == 16) ? c16 : {4'b0, c12};
    return r[PIX_W-1:0];
  endfunction

  assign pix_word = tp_sel ? bar_colour(3'(pix_x / BAR_X))
                           : form_pixel(fmt, byte_a, data_p0[7:0]);
`else
  assign pix_word = form_pixel(fmt, byte_a, data_p0[7:0]);
`endif

  // stage p0/p1: registered sync copies and their delayed versions for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_p0   <= 1'b0;
      hr_p0   <= 1'b0;
      vs_p1   <= 1'b0;
      hr_p1   <= 1'b0;
      data_p0 <= '0;
    end else begin
      vs_p0   <= cam_vsync;
      hr_p0   <= cam_href;
      vs_p1   <= vs_p0;
      hr_p1   <= hr_p0;
      data_p0 <= cam_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= frame_end;
      case (state)
        IDLE:    if (enable) state <= ARM;
        ARM:     if (vs_fall) state <= FRAME;
        FRAME:   if (vs_rise) begin
                   state     <= enable ? ARM : IDLE;
                   frame_cnt <= frame_cnt + 8'd1;
                 end
        default: state <= IDLE;
      endcase
    end
  end

  // pix_x stops at H_ACT, so over-long lines crop silently instead of flagging line_err
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase     <= 1'b0;
      byte_a    <= '0;
      pix_x     <= '0;
      line_y    <= '0;
      line_base <= '0;
    end else if (state == ARM && vs_fall) begin
      phase     <= 1'b0;
      pix_x     <= '0;
      line_y    <= '0;
      line_base <= '0;
    end else if (in_frame) begin
      if (hr_p0) begin
        phase <= ~phase;
        if (!phase) byte_a <= data_p0[7:0];
        else if (pix_x < H_MAX) pix_x <= pix_x + 1'b1;
      end else begin
        phase <= 1'b0;
        if (hr_fall) begin
          pix_x     <= '0;
          line_y    <= sat_inc_y(line_y);
          line_base <= line_base + H_STEP;
        end
      end
    end else begin
      phase <= 1'b0;
    end
  end

  // stage p1 -> output: registered frame-buffer write port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= pix_ok;
      if (pix_ok) begin
        wr_addr <= line_base + ADDR_W'(pix_x);
        wr_data <= pix_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      line_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      line_err  <= line_bad | (line_err & ~err_clr);
      frame_err <= frame_bad | (frame_err & ~err_clr);
    end
  end

endmodule
